// File: rtl/keccak_io_ctrl.sv
// keccak_io_ctrl: packs 64-bit message words into rate blocks, applies
// SHA-3 padding, drives the permutation core and streams digest lanes.
// Ports: clk, rst_n (async, active-low); start; din/din_valid/last_block
// with buffer_full stall; dout/dout_valid/dout_ack/ready digest stream;
// done; perm_start/perm_block to the core, perm_done/perm_lanes back.
`timescale 1ns/1ps
module keccak_io_ctrl #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [63:0]              din,
    input  logic                     din_valid,
    input  logic                     last_block,
    output logic                     buffer_full,
    output logic                     ready,
    output logic [63:0]              dout,
    output logic                     dout_valid,
    input  logic                     dout_ack,
    output logic                     done,
    output logic                     perm_start,
    output logic [RATE_LANES*64-1:0] perm_block,
    input  logic                     perm_done,
    input  logic [OUT_LANES*64-1:0]  perm_lanes
);

    localparam int CW = $clog2(RATE_LANES + 1);
    localparam int OW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RATE_LANES);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATE_LANES - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_LANES - 1);
    localparam logic [63:0]   PAD_LO   = 64'h0000_0000_0000_0006;
    localparam logic [63:0]   PAD_HI   = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [63:0]   lanes [RATE_LANES];
    logic [63:0]   outs  [OUT_LANES];
    logic [CW-1:0] lane_cnt;
    logic [OW-1:0] out_cnt;
    logic          last_seen;
    logic          pad_pending;
    logic          final_blk;
    logic          perm_start_q;

    logic fill_full;
    logic accept;
    logic reach_full;

    assign fill_full  = (lane_cnt == FULL_CNT);
    assign accept     = (state == S_FILL) && din_valid && !fill_full;
    assign reach_full = fill_full || (accept && lane_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_FILL;
            end
            S_FILL: begin
                if (last_block) state_nx = S_PAD;
                else if (reach_full) state_nx = S_ABSORB;
            end
            S_PAD: begin
                state_nx = S_ABSORB;
            end
            S_ABSORB: begin
                if (perm_done) begin
                    if (final_blk) state_nx = S_SQUEEZE;
                    else if (pad_pending) state_nx = S_PAD;
                    else state_nx = S_FILL;
                end
            end
            S_SQUEEZE: begin
                if (dout_ack && out_cnt == OUT_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                if (start) state_nx = S_FILL;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
            for (int i = 0; i < OUT_LANES; i++) outs[i] <= '0;
            lane_cnt     <= '0;
            out_cnt      <= '0;
            last_seen    <= 1'b0;
            pad_pending  <= 1'b0;
            final_blk    <= 1'b0;
            perm_start_q <= 1'b0;
        end else begin
            // Single-cycle pulse on every entry into ABSORB.
            perm_start_q <= (state_nx == S_ABSORB) && (state != S_ABSORB);
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
                        lane_cnt    <= '0;
                        last_seen   <= 1'b0;
                        pad_pending <= 1'b0;
                        final_blk   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        lanes[lane_cnt] <= din;
                        lane_cnt        <= lane_cnt + CW'(1);
                    end
                    if (last_block) last_seen <= 1'b1;
                    else if (reach_full) final_blk <= 1'b0;
                end
                S_PAD: begin
                    if (fill_full) begin
                        // Padding needs a fresh block after this one.
                        pad_pending <= 1'b1;
                        final_blk   <= 1'b0;
                    end else begin
                        // Both pad bytes may fall in the same lane.
                        for (int i = 0; i < RATE_LANES; i++) begin
                            lanes[i] <= lanes[i]
                                ^ ((CW'(i) == lane_cnt) ? PAD_LO : '0)
                                ^ ((i == RATE_LANES - 1) ? PAD_HI : '0);
                        end
                        final_blk <= last_seen;
                    end
                end
                S_ABSORB: begin
                    if (perm_done) begin
                        for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
                        lane_cnt <= '0;
                        if (final_blk) begin
                            for (int i = 0; i < OUT_LANES; i++)
                                outs[i] <= perm_lanes[64*i +: 64];
                            out_cnt <= '0;
                        end else if (pad_pending) begin
                            pad_pending <= 1'b0;
                        end
                    end
                end
                S_SQUEEZE: begin
                    if (dout_ack) out_cnt <= out_cnt + OW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        buffer_full = 1'b1;
        ready       = 1'b0;
        dout_valid  = 1'b0;
        dout        = '0;
        done        = 1'b0;
        unique case (state)
            S_FILL: begin
                buffer_full = fill_full;
            end
            S_SQUEEZE: begin
                ready      = 1'b1;
                dout_valid = 1'b1;
                dout       = outs[out_cnt];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign perm_start = perm_start_q;

    for (genvar g = 0; g < RATE_LANES; g++) begin : g_blk
        assign perm_block[64*g +: 64] = lanes[g];
    end

endmodule
